perceptron_train_scheduler: RTL and testbench

- Sequences the perceptron branch predictor between prediction and resolution.
- Holds an in-order in-flight queue of issued predictions, each with the table index, history snapshot, predicted direction and confidence |y|.
- Maintains the speculative global history fed to the predictor lookup.
- On in-order resolution, decides whether training is needed (mispredict or |y| <= THRESHOLD), issues one training command to the table write port, and flushes wrong-path entries on a mispredict.

---
 rtl/perceptron_pkg.sv | 21 ++
 rtl/pts_inflight_fifo.sv | 48 ++++
 rtl/perceptron_train_scheduler.sv | 135 +++++++++++++
 tb/tb_perceptron_train_scheduler.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/perceptron_pkg.sv
// Shared types and default widths for the perceptron train scheduler slice.
package perceptron_pkg;

  localparam int unsigned HISTORY_LEN = 12;
  localparam int unsigned INDEX_SIZE  = 8;
  localparam int unsigned THRESHOLD   = 38;
  localparam int unsigned CONF_W      = 8;

  typedef struct packed {
    logic [INDEX_SIZE-1:0]  index;
    logic [HISTORY_LEN-1:0] history;
    logic                   pred;
    logic [CONF_W-1:0]      conf;
  } inflight_entry_t;

  typedef enum logic {
    IDLE  = 1'b0,
    TRAIN = 1'b1
  } state_t;

endpackage

// File: rtl/pts_inflight_fifo.sv
// In-order circular buffer of in-flight predictions; flush drops everything
// behind the entry being popped.
module pts_inflight_fifo
  import perceptron_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  inflight_entry_t          push_data,
  input  logic                     pop,
  input  logic                     flush,
  output inflight_entry_t          head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  inflight_entry_t    mem [DEPTH];
  logic [PTR_W-1:0]   head_ptr;
  logic [PTR_W-1:0]   tail_ptr;

  assign head = mem[head_ptr];

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) mem[tail_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else if (flush) begin
      head_ptr <= head_ptr + PTR_W'(1);
      tail_ptr <= head_ptr + PTR_W'(1);
      count    <= '0;
    end else begin
      if (push) tail_ptr <= tail_ptr + PTR_W'(1);
      if (pop)  head_ptr <= head_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

endmodule

// File: rtl/perceptron_train_scheduler.sv
// Sequences perceptron predictions through resolution and training.
// Define PTS_STATS_EN to add saturating branch/mispredict/train counters.
module perceptron_train_scheduler
  import perceptron_pkg::*;
#(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned THRESHOLD = perceptron_pkg::THRESHOLD
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pred_valid,
  output logic                     pred_ready,
  input  logic [63:0]              pred_ip,
  input  logic                     pred_taken,
  input  logic [CONF_W-1:0]        pred_conf,
  output logic [HISTORY_LEN-1:0]   spec_history,
  input  logic                     res_valid,
  output logic                     res_ready,
  input  logic                     res_taken,
  output logic                     train_valid,
  input  logic                     train_ready,
  output logic [INDEX_SIZE-1:0]    train_index,
  output logic [HISTORY_LEN-1:0]   train_history,
  output logic                     train_taken,
  output logic                     mispredict,
  output logic [$clog2(DEPTH):0]   occupancy
`ifdef PTS_STATS_EN
  ,
  output logic [31:0]              stat_branches,
  output logic [31:0]              stat_mispredicts,
  output logic [31:0]              stat_trains
`endif
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  state_t             state;
  state_t             next_state;
  inflight_entry_t    head;
  inflight_entry_t    push_entry;
  logic [CNT_W-1:0]   count;
  logic               push;
  logic               resolve;
  logic               miss_c;
  logic               need_c;
  logic               unused_ip;

  assign unused_ip = ^pred_ip[63:INDEX_SIZE];

  assign miss_c  = head.pred != res_taken;
  assign need_c  = miss_c || (head.conf <= CONF_W'(THRESHOLD));
  assign push    = pred_valid && pred_ready;
  assign resolve = res_valid && res_ready;

  assign push_entry = '{index:   pred_ip[INDEX_SIZE-1:0],
                        history: spec_history,
                        pred:    pred_taken,
                        conf:    pred_conf};

  assign train_valid = (state == TRAIN);
  assign occupancy   = count;

  pts_inflight_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (resolve),
    .flush     (resolve && miss_c),
    .head      (head),
    .count     (count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    pred_ready = 1'b0;
    res_ready  = 1'b0;
    case (state)
      IDLE: begin
        pred_ready = (count != CNT_W'(DEPTH));
        res_ready  = (count != '0);
        if (res_valid && (count != '0) && need_c) next_state = TRAIN;
      end
      TRAIN: begin
        if (train_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // A mispredict rebuilds history from the resolved branch, overriding any push.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      spec_history  <= '0;
      mispredict    <= 1'b0;
      train_index   <= '0;
      train_history <= '0;
      train_taken   <= 1'b0;
    end else begin
      mispredict <= resolve && miss_c;
      if (resolve) begin
        train_index   <= head.index;
        train_history <= head.history;
        train_taken   <= res_taken;
      end
      if (resolve && miss_c)
        spec_history <= {head.history[HISTORY_LEN-2:0], res_taken};
      else if (push)
        spec_history <= {spec_history[HISTORY_LEN-2:0], pred_taken};
    end
  end

`ifdef PTS_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
      stat_trains      <= '0;
    end else begin
      if (resolve && (stat_branches != '1))
        stat_branches <= stat_branches + 32'(1);
      if (resolve && miss_c && (stat_mispredicts != '1))
        stat_mispredicts <= stat_mispredicts + 32'(1);
      if ((state == TRAIN) && train_ready && (stat_trains != '1))
        stat_trains <= stat_trains + 32'(1);
    end
  end
`endif

endmodule

// File: tb/tb_perceptron_train_scheduler.sv
// Scoreboard bench for perceptron_train_scheduler: directed stimulus queues
// expected train commands and mispredict results; a monitor checks them.
module tb_perceptron_train_scheduler;
  import perceptron_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pred_valid = 1'b0;
  logic        pred_ready;
  logic [63:0] pred_ip = '0;
  logic        pred_taken = 1'b0;
  logic [7:0]  pred_conf = '0;
  logic [11:0] spec_history;
  logic        res_valid = 1'b0;
  logic        res_ready;
  logic        res_taken = 1'b0;
  logic        train_valid;
  logic        train_ready = 1'b0;
  logic [7:0]  train_index;
  logic [11:0] train_history;
  logic        train_taken;
  logic        mispredict;
  logic [3:0]  occupancy;
`ifdef PTS_STATS_EN
  logic [31:0] stat_branches, stat_mispredicts, stat_trains;
`endif

  perceptron_train_scheduler dut (
    .clk           (clk),
    .reset         (reset),
    .pred_valid    (pred_valid),
    .pred_ready    (pred_ready),
    .pred_ip       (pred_ip),
    .pred_taken    (pred_taken),
    .pred_conf     (pred_conf),
    .spec_history  (spec_history),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_taken     (res_taken),
    .train_valid   (train_valid),
    .train_ready   (train_ready),
    .train_index   (train_index),
    .train_history (train_history),
    .train_taken   (train_taken),
    .mispredict    (mispredict),
    .occupancy     (occupancy)
`ifdef PTS_STATS_EN
    ,
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts),
    .stat_trains      (stat_trains)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  idx;
    logic [11:0] hist;
    logic        tk;
  } train_exp_t;

  train_exp_t  train_q[$];
  logic [11:0] mis_q[$];
  logic        dir_q[$];
  train_exp_t  t_exp;
  logic [11:0] m_exp;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int ip, input logic tk, input int conf);
    pred_valid = 1'b1;
    pred_ip    = 64'(ip);
    pred_taken = tk;
    pred_conf  = 8'(conf);
    step();
    pred_valid = 1'b0;
  endtask

  task automatic resolve(input logic tk);
    res_valid = 1'b1;
    res_taken = tk;
    step();
    res_valid = 1'b0;
  endtask

  // Monitor: every train handshake and mispredict pulse consumes one expectation.
  always @(negedge clk) begin
    if (!reset) begin
      if (train_valid && train_ready) begin
        if (train_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL train_unexpected: got index 0x%0h expected no command", train_index);
        end else begin
          t_exp = train_q.pop_front();
          check("sb_train_index", 32'(train_index), 32'(t_exp.idx));
          check("sb_train_history", 32'(train_history), 32'(t_exp.hist));
          check("sb_train_taken", 32'(train_taken), 32'(t_exp.tk));
        end
      end
      if (mispredict) begin
        if (mis_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL mispredict_unexpected: got pulse expected none, history 0x%0h", spec_history);
        end else begin
          m_exp = mis_q.pop_front();
          check("sb_mis_history", 32'(spec_history), 32'(m_exp));
          check("sb_mis_occupancy", 32'(occupancy), 32'd0);
        end
      end
    end
  end

  initial begin
    logic [11:0] pat;
    pat = 12'h0A5;

    repeat (3) step();
    reset = 1'b0;
    step();
    check("rst_occupancy", 32'(occupancy), 32'd0);
    check("rst_spec_history", 32'(spec_history), 32'd0);
    check("rst_train_valid", 32'(train_valid), 32'd0);
    check("rst_mispredict", 32'(mispredict), 32'd0);
    check("rst_pred_ready", 32'(pred_ready), 32'd1);
    check("rst_res_ready", 32'(res_ready), 32'd0);

    // Resolve while empty is ignored.
    resolve(1'b0);
    check("empty_res_occupancy", 32'(occupancy), 32'd0);
    check("empty_res_mispredict", 32'(mispredict), 32'd0);

    push(32'h10, 1'b1, 50);
    push(32'h20, 1'b1, 50);
    push(32'h30, 1'b1, 50);
    check("push3_occupancy", 32'(occupancy), 32'd3);
    check("push3_spec_history", 32'(spec_history), 32'h007);
    check("push3_pred_ready", 32'(pred_ready), 32'd1);

    resolve(1'b1);
    check("ok_res_train_valid", 32'(train_valid), 32'd0);
    check("ok_res_occupancy", 32'(occupancy), 32'd2);
    check("ok_res_mispredict", 32'(mispredict), 32'd0);

    // Low-confidence correct prediction trains; stall train_ready.
    push(32'h44, 1'b1, 20);
    check("p44_spec_history", 32'(spec_history), 32'h00F);
    resolve(1'b1);
    resolve(1'b1);
    train_q.push_back('{idx: 8'h44, hist: 12'h007, tk: 1'b1});
    resolve(1'b1);
    check("lowconf_train_valid", 32'(train_valid), 32'd1);
    for (int i = 0; i < 3; i++) begin
      check("stall_train_index", 32'(train_index), 32'h44);
      check("stall_train_history", 32'(train_history), 32'h007);
      check("stall_pred_ready", 32'(pred_ready), 32'd0);
      check("stall_res_ready", 32'(res_ready), 32'd0);
      step();
    end
    train_ready = 1'b1;
    step();
    train_ready = 1'b0;
    check("train_done_valid", 32'(train_valid), 32'd0);
    check("train_done_occupancy", 32'(occupancy), 32'd0);

    // Shape history to 0x0A5, also exercising the full condition.
    for (int i = 0; i < 8; i++) push(32'h100 + i, pat[11-i], 50);
    check("full_occupancy", 32'(occupancy), 32'd8);
    check("full_pred_ready", 32'(pred_ready), 32'd0);
    push(32'h1FF, 1'b1, 50);
    check("full_reject_occupancy", 32'(occupancy), 32'd8);
    check("full_reject_history", 32'(spec_history), 32'hF0A);
    for (int i = 0; i < 8; i++) resolve(pat[11-i]);
    check("drain_res_ready", 32'(res_ready), 32'd0);
    for (int i = 0; i < 4; i++) push(32'h110 + i, pat[3-i], 50);
    for (int i = 0; i < 4; i++) resolve(pat[3-i]);
    check("shaped_history", 32'(spec_history), 32'h0A5);

    // Mispredict with a same-cycle push that must be discarded.
    for (int i = 0; i < 4; i++) push(32'h50 + i, 1'b1, 50);
    check("mis_pre_history", 32'(spec_history), 32'hA5F);
    train_q.push_back('{idx: 8'h50, hist: 12'h0A5, tk: 1'b0});
    mis_q.push_back(12'h14A);
    res_valid  = 1'b1;
    res_taken  = 1'b0;
    pred_valid = 1'b1;
    pred_ip    = 64'h99;
    pred_taken = 1'b1;
    pred_conf  = 8'd50;
    step();
    res_valid  = 1'b0;
    pred_valid = 1'b0;
    check("mis_pulse", 32'(mispredict), 32'd1);
    check("mis_occupancy", 32'(occupancy), 32'd0);
    check("mis_spec_history", 32'(spec_history), 32'h14A);
    check("mis_train_valid", 32'(train_valid), 32'd1);
    step();
    check("mis_pulse_width", 32'(mispredict), 32'd0);
    train_ready = 1'b1;
    step();
    train_ready = 1'b0;
    check("mis_train_done", 32'(train_valid), 32'd0);

    // Pointer wrap with simultaneous push and resolve at count 7.
    for (int i = 0; i < 8; i++) begin
      push(32'h200 + i, i[0], 50);
      dir_q.push_back(i[0]);
    end
    resolve(dir_q.pop_front());
    check("wrap_start_occupancy", 32'(occupancy), 32'd7);
    for (int k = 0; k < 20; k++) begin
      res_valid  = 1'b1;
      res_taken  = dir_q.pop_front();
      pred_valid = 1'b1;
      pred_ip    = 64'(32'h300 + k);
      pred_taken = k[1];
      pred_conf  = 8'd60;
      dir_q.push_back(k[1]);
      step();
      res_valid  = 1'b0;
      pred_valid = 1'b0;
      check("wrap_occupancy", 32'(occupancy), 32'd7);
    end
    while (dir_q.size() > 0) resolve(dir_q.pop_front());
    check("wrap_end_occupancy", 32'(occupancy), 32'd0);
    check("wrap_end_pred_ready", 32'(pred_ready), 32'd1);

    // Asynchronous reset while a train command is stalled.
    push(32'h60, 1'b1, 10);
    resolve(1'b1);
    check("pre_reset_train_valid", 32'(train_valid), 32'd1);
    step();
    reset = 1'b1;
    #1;
    check("async_rst_train_valid", 32'(train_valid), 32'd0);
    check("async_rst_occupancy", 32'(occupancy), 32'd0);
    check("async_rst_history", 32'(spec_history), 32'd0);
    step();
    reset = 1'b0;
    step();
    check("post_rst_pred_ready", 32'(pred_ready), 32'd1);
    check("post_rst_res_ready", 32'(res_ready), 32'd0);

    check("train_q_drained", 32'(train_q.size()), 32'd0);
    check("mis_q_drained", 32'(mis_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
